// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the sequential Booth multiplier.
// Holds the FSM state enum, the step count per radix and the recode-select encoding.
// Build option: define BOOTH_RADIX4_EN for radix-4 steps (two bits per cycle).
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Partial-product selection produced by the recoder.
    typedef enum logic [2:0] {
        SEL_ZERO   = 3'd0,
        SEL_ADD_M  = 3'd1,
        SEL_SUB_M  = 3'd2,
        SEL_ADD_2M = 3'd3,
        SEL_SUB_2M = 3'd4
    } sel_t;

`ifdef BOOTH_RADIX4_EN
    localparam int unsigned SHIFT = 2;
`else
    localparam int unsigned SHIFT = 1;
`endif

    // Guard bits on the accumulator: one per bit retired each step, so
    // that +/-M (radix-2) or +/-2M (radix-4) of the most-negative M fits.
    localparam int unsigned GUARD = SHIFT;

    function automatic int unsigned iter_of(input int unsigned width);
        return width / SHIFT;
    endfunction

    // trip = {Q[1], Q[0], q(-1)}; radix-2 looks only at the low pair.
    function automatic sel_t recode(input logic [2:0] trip);
        sel_t s;
        s = SEL_ZERO;
`ifdef BOOTH_RADIX4_EN
        unique case (trip)
            3'b001, 3'b010: s = SEL_ADD_M;
            3'b011:         s = SEL_ADD_2M;
            3'b100:         s = SEL_SUB_2M;
            3'b101, 3'b110: s = SEL_SUB_M;
            default:        s = SEL_ZERO;
        endcase
`else
        unique case (trip[1:0])
            2'b01:   s = SEL_ADD_M;
            2'b10:   s = SEL_SUB_M;
            default: s = SEL_ZERO;
        endcase
`endif
        return s;
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_step.sv
// booth_step: one combinational Booth step (recode, add/sub, arithmetic shift).
// Ports: acc/q/qm1/m in -> acc_nxt/q_nxt/qm1_nxt out. Radix via BOOTH_RADIX4_EN.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = WIDTH + GUARD
) (
    input  logic [AW-1:0]    acc,
    input  logic [WIDTH-1:0] q,
    input  logic             qm1,
    input  logic [WIDTH-1:0] m,
    output logic [AW-1:0]    acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             qm1_nxt
);

    sel_t                sel;
    logic [AW-1:0]       m_ext;
    logic [AW-1:0]       m2_ext;
    logic [AW-1:0]       sum;
    logic [AW+WIDTH:0]   cat;
    logic [AW+WIDTH:0]   shifted;

    assign sel    = recode({q[1], q[0], qm1});
    assign m_ext  = {{GUARD{m[WIDTH-1]}}, m};
    assign m2_ext = m_ext << 1;

    always_comb begin
        sum = acc;
        unique case (sel)
            SEL_ADD_M:  sum = acc + m_ext;
            SEL_SUB_M:  sum = acc - m_ext;
            SEL_ADD_2M: sum = acc + m2_ext;
            SEL_SUB_2M: sum = acc - m2_ext;
            default:    sum = acc;
        endcase
    end

    // Shift the whole {A,Q,q(-1)} register as one signed quantity.
    assign cat     = {sum, q, qm1};
    assign shifted = $signed(cat) >>> SHIFT;

    assign acc_nxt = shifted[AW+WIDTH:WIDTH+1];
    assign q_nxt   = shifted[WIDTH:1];
    assign qm1_nxt = shifted[0];

endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential signed Booth multiplier, out = a*b.
// Ports: clk, rst (async high), start, a, b -> busy, done (pulse), out. Option: BOOTH_RADIX4_EN.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int          AW   = WIDTH + GUARD;
    localparam int unsigned ITER = iter_of(WIDTH);
    localparam int          CW   = $clog2(ITER + 1);

    state_t state, state_nxt;

    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;

    logic [AW-1:0]    acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             qm1_nxt;

    logic accept;
    logic last;

    booth_step #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_step (
        .acc     (acc),
        .q       (q),
        .qm1     (qm1),
        .m       (m),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .qm1_nxt (qm1_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            q   <= '0;
            qm1 <= 1'b0;
            m   <= '0;
            cnt <= '0;
            out <= '0;
        end else if (accept) begin
            acc <= '0;
            q   <= b;
            qm1 <= 1'b0;
            m   <= a;
            cnt <= CW'(ITER);
        end else if (state == RUN) begin
            acc <= acc_nxt;
            q   <= q_nxt;
            qm1 <= qm1_nxt;
            cnt <= cnt - CW'(1);
            // Guard bits are only sign copies by now; drop them.
            if (last) begin
                out <= {acc_nxt[WIDTH-1:0], q_nxt};
            end
        end
    end

endmodule

// File: doc/booth_seq_multiplier.md
BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; it SHALL be even and at least 4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 start  input  1  request to begin a multiplication; sampled on the rising edge.
REQ-005 a  input  WIDTH  signed multiplicand M; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  signed multiplier Q; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a multiplication is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse marking out as freshly valid.
REQ-009 out  output  2*WIDTH  signed product a*b.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 start SHALL be accepted only in IDLE or DONE; the accepting edge loads M, Q and q(-1)=0, clears the accumulator, loads the step counter with ITER, and enters RUN.
REQ-012 start in RUN SHALL be ignored: operands are not resampled and timing is unchanged.
REQ-013 In RUN, each edge SHALL perform exactly one Booth step (recode, add/subtract, arithmetic right shift of {A,Q,q(-1)}) and decrement the counter.
REQ-014 Radix-2 step: pair {Q[0],q(-1)}: 01 -> A+M; 10 -> A-M; 00/11 -> no add; then shift right arithmetically by 1.
REQ-015 The edge that executes the last step SHALL enter DONE and load out with {A,Q} truncated to 2*WIDTH bits.
REQ-016 done SHALL be high exactly during the DONE cycle; busy SHALL be high exactly during the RUN cycles.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high in the cycle after edge ITER.
REQ-018 From DONE without start, the next edge SHALL return to IDLE; out SHALL hold its value until the next DONE or reset.
REQ-019 The accumulator SHALL carry guard bits (WIDTH+1 for radix-2, WIDTH+2 for radix-4), so that M = most-negative value gives an exact result.
REQ-020 The result SHALL equal the exact signed product for all 2^(2*WIDTH) operand pairs.

Reset
REQ-021 Asserting rst at any time, including mid-RUN, SHALL immediately force state IDLE, busy=0, done=0 and out=0, and clear all internal registers.
REQ-022 After rst deasserts, the first start SHALL be accepted under REQ-011; no aborted partial result SHALL ever appear on out.

Configuration
REQ-023 Macro BOOTH_RADIX4_EN: when defined, each step SHALL recode the triple {Q[1],Q[0],q(-1)} as 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M, then shift right arithmetically by 2, with ITER = WIDTH/2.
REQ-024 When BOOTH_RADIX4_EN is undefined, the radix-2 step (REQ-014) SHALL be used with ITER = WIDTH; the ports and handshake SHALL be identical in both builds.

Structure
REQ-025 Package booth_pkg SHALL hold the state enumeration (IDLE/RUN/DONE), the ITER constant/function of WIDTH and radix, and the recode-select encoding.
REQ-026 The combinational step SHALL be a sub-module booth_step (inputs A, Q, q(-1), M; outputs next A, Q, q(-1)), instantiated once and reused every RUN cycle.

Verification
REQ-027 WIDTH=8, a=100, b=-8, start pulse -> done after ITER+1 cycles (9 radix-2, 5 radix-4), out=-800; busy high for exactly ITER cycles.
REQ-028 a=-128, b=-128 -> out=16384; a=127, b=-128 -> out=-16256; a=-128, b=1 -> out=-128.
REQ-029 a=0, b=-1 -> out=0; a=-1, b=-1 -> out=1; start re-asserted in the DONE cycle with a=3, b=5 -> back-to-back accept, next out=15.
REQ-030 start held high throughout RUN with changing a/b -> result reflects only the operands sampled at acceptance; done pulse is not shortened or extended.
REQ-031 rst pulsed on the 3rd RUN cycle -> busy, done and out drop to 0 asynchronously; a later start with a=-7, b=9 -> out=-63.
REQ-032 Randomised sweep at WIDTH=8 (exhaustive) and WIDTH=16 (10k pairs) in both macro builds -> out matches the reference product every time.
